// File: rtl/ws2812_pixel_serializer_if.sv
// ---------------------------------------------------------------------------
// ws2812_pixel_serializer_if
// Pixel stream handshake between an upstream pixel source and the serializer.
//   pixData  [23:0] GRB pixel word, bit 23 is sent first
//   pixValid        source has a pixel on pixData
//   pixReady        serializer takes the pixel this cycle
// Modports: master = pixel source, slave = serializer.
// ---------------------------------------------------------------------------
interface ws2812_pixel_serializer_if;
    logic [23:0] pixData;
    logic        pixValid;
    logic        pixReady;

    modport master (output pixData, output pixValid, input pixReady);
    modport slave  (input pixData, input pixValid, output pixReady);
endinterface

// File: rtl/ws2812_pixel_serializer.sv
// ---------------------------------------------------------------------------
// ws2812_pixel_serializer
// Frame controller in front of the per-bit WS2812B waveform generator. Takes
// NUM_LEDS GRB pixels per frame, shifts each one out MSB-first as genMode /
// doGen requests paced by genDone, then holds the line in RET for RET_CYCLES
// clocks and pulses frameDone.
//
// Ports:
//   clk        system clock (100 MHz)
//   reset      asynchronous, active-low reset
//   pix        pixel handshake (slave side of ws2812_pixel_serializer_if)
//   genDone    generator finished the current bit (only looked at in SEND)
//   genMode    10 = zero, 11 = one, 00 = RET, 01 = none
//   doGen      generator enable, high for the whole of one bit
//   busy       high in every state but IDLE
//   frameDone  one-cycle pulse in the last RET cycle
//   underrun   (PIXEL_UNDERRUN_EN only) sticky, pixel source too slow
//
// Build option PIXEL_UNDERRUN_EN: arms a 2000-clock timer in WAITPIX; if no
// pixel arrives in time the frame is aborted into a full RET and underrun is
// set until reset. Without it WAITPIX waits indefinitely.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no frame in progress, first pixel accepted here
// SEND    | generator driving the current bit (shiftReg[23])
// GAP     | one-cycle doGen drop between bits so the generator restarts
// WAITPIX | pixel finished, waiting for the next pixel of the frame
// RET     | line held in reset condition for RET_CYCLES clocks
// ---------------------------------------------------------------------------
module ws2812_pixel_serializer #(
    parameter int NUM_LEDS   = 8,
    parameter int RET_CYCLES = 6000
) (
    input  logic                        clk,
    input  logic                        reset,
    ws2812_pixel_serializer_if.slave    pix,
    input  logic                        genDone,
    output logic [1:0]                  genMode,
    output logic                        doGen,
    output logic                        busy,
    output logic                        frameDone
`ifdef PIXEL_UNDERRUN_EN
    ,
    output logic                        underrun
`endif
);

    localparam int LED_W = $clog2(NUM_LEDS) + 1;
    localparam int RET_W = $clog2(RET_CYCLES) + 1;
    localparam logic [LED_W-1:0] LAST_LED = LED_W'(NUM_LEDS - 1);
    localparam logic [RET_W-1:0] RET_LOAD = RET_W'(RET_CYCLES - 1);

`ifdef PIXEL_UNDERRUN_EN
    localparam int UNDERRUN_CYCLES = 2000;
    localparam int WD_W = $clog2(UNDERRUN_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(UNDERRUN_CYCLES - 1);
`endif

    typedef enum logic [2:0] {IDLE, SEND, GAP, WAITPIX, RET} state_t;

    state_t             stateQ, stateD;
    logic [23:0]        shiftReg;
    logic [4:0]         bitCnt;
    logic [LED_W-1:0]   ledCnt;
    logic [RET_W-1:0]   retCnt;
    logic               loadPix, shiftEn, retLoad;
`ifdef PIXEL_UNDERRUN_EN
    logic [WD_W-1:0]    wdCnt;
    logic               wdLoad, setUnderrun;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stateQ <= IDLE;
        else        stateQ <= stateD;
    end

    always_comb begin
        stateD       = stateQ;
        genMode      = 2'b01;
        doGen        = 1'b0;
        pix.pixReady = 1'b0;
        frameDone    = 1'b0;
        loadPix      = 1'b0;
        shiftEn      = 1'b0;
        retLoad      = 1'b0;
`ifdef PIXEL_UNDERRUN_EN
        wdLoad       = 1'b0;
        setUnderrun  = 1'b0;
`endif
        case (stateQ)
            IDLE: begin
                pix.pixReady = 1'b1;
                if (pix.pixValid) begin
                    loadPix = 1'b1;
                    stateD  = SEND;
                end
            end
            SEND: begin
                doGen   = 1'b1;
                genMode = {1'b1, shiftReg[23]};
                if (genDone) begin
                    if (bitCnt != 5'd0) begin
                        stateD = GAP;
                    end else if (ledCnt == LAST_LED) begin
                        retLoad = 1'b1;
                        stateD  = RET;
                    end else begin
`ifdef PIXEL_UNDERRUN_EN
                        wdLoad = 1'b1;
`endif
                        stateD = WAITPIX;
                    end
                end
            end
            GAP: begin
                // Mode stays on the bit just sent; the shift lands at the
                // end of this cycle so SEND sees the next bit.
                genMode = {1'b1, shiftReg[23]};
                shiftEn = 1'b1;
                stateD  = SEND;
            end
            WAITPIX: begin
                pix.pixReady = 1'b1;
                if (pix.pixValid) begin
                    loadPix = 1'b1;
                    stateD  = SEND;
                end
`ifdef PIXEL_UNDERRUN_EN
                else if (wdCnt == '0) begin
                    setUnderrun = 1'b1;
                    retLoad     = 1'b1;
                    stateD      = RET;
                end
`endif
            end
            RET: begin
                genMode = 2'b00;
                if (retCnt == '0) begin
                    frameDone = 1'b1;
                    stateD    = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    assign busy = (stateQ != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shiftReg <= '0;
            bitCnt   <= '0;
            ledCnt   <= '0;
            retCnt   <= '0;
`ifdef PIXEL_UNDERRUN_EN
            wdCnt    <= '0;
            underrun <= 1'b0;
`endif
        end else begin
            if (loadPix) begin
                shiftReg <= pix.pixData;
                bitCnt   <= 5'd23;
                ledCnt   <= (stateQ == IDLE) ? '0 : ledCnt + 1'b1;
            end else if (shiftEn) begin
                shiftReg <= {shiftReg[22:0], 1'b0};
                bitCnt   <= bitCnt - 1'b1;
            end

            if (retLoad)
                retCnt <= RET_LOAD;
            else if (stateQ == RET && retCnt != '0)
                retCnt <= retCnt - 1'b1;

`ifdef PIXEL_UNDERRUN_EN
            if (wdLoad)
                wdCnt <= WD_LOAD;
            else if (stateQ == WAITPIX && wdCnt != '0)
                wdCnt <= wdCnt - 1'b1;
            if (setUnderrun)
                underrun <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_ws2812_pixel_serializer.sv
// ---------------------------------------------------------------------------
// tb_ws2812_pixel_serializer
// Directed bench for ws2812_pixel_serializer with NUM_LEDS=3, RET_CYCLES=6000
// and a generator model that raises genDone after 120 doGen cycles
// (122 clocks per bit including the inter-bit gap).
// Build option PIXEL_UNDERRUN_EN adds the underrun scenario.
// ---------------------------------------------------------------------------
module tb_ws2812_pixel_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       genDone;
    logic [1:0] genMode;
    logic       doGen;
    logic       busy;
    logic       frameDone;
`ifdef PIXEL_UNDERRUN_EN
    logic       underrun;
`endif
    logic       spurGen;

    ws2812_pixel_serializer_if pixIf ();

    ws2812_pixel_serializer #(.NUM_LEDS(3), .RET_CYCLES(6000)) dut (
        .clk       (clk),
        .reset     (reset),
        .pix       (pixIf),
        .genDone   (genDone),
        .genMode   (genMode),
        .doGen     (doGen),
        .busy      (busy),
        .frameDone (frameDone)
`ifdef PIXEL_UNDERRUN_EN
        ,
        .underrun  (underrun)
`endif
    );

    always #5 clk = ~clk;

    // Generator model: genDone in the doGen cycle after 120 doGen cycles.
    int genCnt = 0;
    always @(posedge clk) genCnt <= (doGen === 1'b1) ? genCnt + 1 : 0;
    assign genDone = ((doGen === 1'b1) && (genCnt == 120)) || spurGen;

    // Monitor: cumulative counters, read by the main sequence only while idle.
    int   busyCnt = 0, doGenCnt = 0, readyBusyCnt = 0, fdCnt = 0, gotN = 0;
    logic gotBits [0:1023];
    logic prevDoGen = 1'b0;
    always @(negedge clk) begin
        if (busy === 1'b1) busyCnt <= busyCnt + 1;
        if (doGen === 1'b1) doGenCnt <= doGenCnt + 1;
        if (busy === 1'b1 && pixIf.pixReady === 1'b1) readyBusyCnt <= readyBusyCnt + 1;
        if (frameDone === 1'b1) fdCnt <= fdCnt + 1;
        if (doGen === 1'b1 && prevDoGen == 1'b0 && gotN < 1024) begin
            gotBits[gotN] <= genMode[0];
            gotN          <= gotN + 1;
        end
        prevDoGen <= (doGen === 1'b1);
    end

    int checks = 0;
    int errors = 0;
    int sBusy, sDo, sRdy, sFd, sN;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        sBusy = busyCnt; sDo = doGenCnt; sRdy = readyBusyCnt; sFd = fdCnt; sN = gotN;
    endtask

    // Called at a negedge; hands one pixel over and checks the first bit.
    task automatic pushPix(input logic [23:0] d);
        int n = 0;
        while (pixIf.pixReady !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("readyWait", pixIf.pixReady, 1);
        pixIf.pixValid = 1'b1;
        pixIf.pixData  = d;
        @(posedge clk);
        @(negedge clk);
        pixIf.pixValid = 1'b0;
        pixIf.pixData  = 24'($urandom);
        chk("firstBitDoGen", doGen, 1);
        chk("firstBitMode", genMode, {1'b1, d[23]});
    endtask

    task automatic waitFrameDone();
        int n = 0;
        while (frameDone !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("frameDoneSeen", frameDone, 1);
        @(negedge clk);
        chk("readyAfterFrame", pixIf.pixReady, 1);
        chk("idleAfterFrame", busy, 0);
    endtask

    task automatic checkBits(input string tag, input logic [23:0] w0, input logic [23:0] w1,
                             input logic [23:0] w2);
        logic [71:0] all;
        all = {w0, w1, w2};
        chk({tag, "Count"}, gotN - sN, 72);
        for (int i = 0; i < 72; i++) chk(tag, gotBits[sN + i], all[71 - i]);
    endtask

    initial begin
        logic flag;
        int   n;
        reset          = 1'b0;
        spurGen        = 1'b0;
        pixIf.pixValid = 1'b0;
        pixIf.pixData  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rstReady", pixIf.pixReady, 1);
        chk("rstDoGen", doGen, 0);
        chk("rstMode", genMode, 2'b01);
        chk("rstBusy", busy, 0);
        chk("rstFrameDone", frameDone, 0);
`ifdef PIXEL_UNDERRUN_EN
        chk("rstUnderrun", underrun, 0);
`endif
        reset = 1'b1;
        @(negedge clk);

        // Spurious genDone in IDLE
        spurGen = 1'b1;
        flag    = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (busy !== 1'b0 || pixIf.pixReady !== 1'b1) flag = 1'b1;
        end
        spurGen = 1'b0;
        chk("idleSpurGen", flag, 0);

        // Frame 1: continuous pixels
        snap();
        pushPix(24'hFFFFFF);
        pushPix(24'h000000);
        pushPix(24'h00FF00);
        waitFrameDone();
        chk("f1Busy", busyCnt - sBusy, 72 * 122 - 1 + 6000);
        chk("f1DoGen", doGenCnt - sDo, 72 * 121);
        chk("f1ReadyInFrame", readyBusyCnt - sRdy, 2);
        chk("f1FrameDone", fdCnt - sFd, 1);
        checkBits("f1Bit", 24'hFFFFFF, 24'h000000, 24'h00FF00);

        // Frame 2: ignored pixValid, spurious genDone in GAP/RET, delayed pixel
        snap();
        pushPix(24'hA50000);
        pixIf.pixValid = 1'b1;
        pixIf.pixData  = 24'h000000;
        flag = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (pixIf.pixReady !== 1'b0) flag = 1'b1;
        end
        pixIf.pixValid = 1'b0;
        chk("sendNoReady", flag, 0);

        n = 0;
        while (!(busy === 1'b1 && doGen === 1'b0 && genMode[1] === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("gapFound", genMode, 2'b11);
        spurGen = 1'b1;
        @(negedge clk);
        spurGen = 1'b0;
        chk("gapSpurResume", doGen, 1);

        n = 0;
        while (pixIf.pixReady !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        flag = 1'b0;
        repeat (50) begin
            if (doGen !== 1'b0 || genMode !== 2'b01 || pixIf.pixReady !== 1'b1) flag = 1'b1;
            @(negedge clk);
        end
        chk("waitPixIdle", flag, 0);
        pushPix(24'h5A3C81);
        pushPix(24'h00000F);

        n = 0;
        while (!(busy === 1'b1 && genMode === 2'b00) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("retMode", genMode, 2'b00);
        spurGen        = 1'b1;
        pixIf.pixValid = 1'b1;
        pixIf.pixData  = 24'hFFFFFF;
        flag = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (pixIf.pixReady !== 1'b0 || busy !== 1'b1 || doGen !== 1'b0) flag = 1'b1;
        end
        spurGen        = 1'b0;
        pixIf.pixValid = 1'b0;
        chk("retIgnores", flag, 0);
        waitFrameDone();
        chk("f2Busy", busyCnt - sBusy, 72 * 122 - 1 + 6000 + 50);
        chk("f2FrameDone", fdCnt - sFd, 1);
        checkBits("f2Bit", 24'hA50000, 24'h5A3C81, 24'h00000F);

        // Frame 3: reset during LED 2
        snap();
        pushPix(24'h123456);
        pushPix(24'hABCDEF);
        repeat (500) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midRstDoGen", doGen, 0);
        chk("midRstMode", genMode, 2'b01);
        chk("midRstReady", pixIf.pixReady, 1);
        chk("midRstBusy", busy, 0);
        chk("midRstFrameDone", frameDone, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midRstNoFrameDone", fdCnt - sFd, 0);
        chk("midRstIdle", busy, 0);

        // Frame 4: normal frame after reset
        snap();
        pushPix(24'h800001);
        pushPix(24'h7FFFFE);
        pushPix(24'hC3C3C3);
        waitFrameDone();
        chk("f4Busy", busyCnt - sBusy, 72 * 122 - 1 + 6000);
        chk("f4FrameDone", fdCnt - sFd, 1);
        checkBits("f4Bit", 24'h800001, 24'h7FFFFE, 24'hC3C3C3);

`ifdef PIXEL_UNDERRUN_EN
        // Frame 5: second pixel withheld
        chk("underrunClear", underrun, 0);
        snap();
        pushPix(24'hF0F0F0);
        n = 0;
        while (pixIf.pixReady !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (pixIf.pixReady === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("underrunWait", n, 2000);
        chk("underrunRetMode", genMode, 2'b00);
        chk("underrunSet", underrun, 1);
        n = 1;
        while (frameDone !== 1'b1 && n < 7000) begin
            @(negedge clk);
            n++;
        end
        chk("underrunRetLen", n, 6000);
        @(negedge clk);
        chk("underrunFrameDone", fdCnt - sFd, 1);
        chk("underrunSticky", underrun, 1);
        chk("underrunIdle", busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
